ras_ckpt_queue: RTL and testbench
=================================

Name: ras_ckpt_queue

Overview:
- Circular checkpoint queue that captures the RAS speculative state snapshot (rasTop, listTop, inflightTop, topInvalid) for every predicted fetch block.
- Replays the snapshot of a mispredicted block on redirect, and retires snapshots in order at commit.
- Sits beside the FSQ in the frontend. It is the producer side of the RAS squash/redirect rasInfo path, and the RAS is the consumer.

Parameters:
- DEPTH, 32, number of checkpoint entries; must be a power of 2.
- INFL_W, 4, RAS inflight index width; rasTop and listTop are each {dir, idx} = INFL_W+1 bits.
- RAS_W, 4, committed RAS pointer width (inflightTop).
- SNAP_W, 2*(INFL_W+1)+RAS_W+1, packed snapshot width, derived.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enq_valid  in  1  new prediction snapshot offered
- enq_ready  out  1  queue can accept a snapshot this cycle
- enq_snap  in  SNAP_W  snapshot {rasTop, listTop, inflightTop, topInvalid}
- enq_idx  out  log2(DEPTH)  slot index assigned to the current enq (tail.idx)
- redirect_valid  in  1  backend/predecode redirect for block redirect_idx
- redirect_idx  in  log2(DEPTH)  slot of the mispredicted block
- rd_valid  out  1  replayed snapshot valid, one cycle after redirect
- rd_snap  out  SNAP_W  replayed snapshot
- redirect_err  out  1  pulses when redirect_idx is not in [head, tail)
- commit_valid  in  1  oldest block committed; pop head
- commit_snap  out  SNAP_W  snapshot at head, combinational
- flush  in  1  drop all entries
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  head == tail

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values: head = tail = 0 with wrap bits 0; rd_valid = 0; rd_snap = 0; redirect_err = 0; count = 0; empty = 1; enq_ready = 1. Snapshot storage is not reset.
- Pointers are {wrap, idx}; idx width is log2(DEPTH).
  - full: idx equal and wrap different.
  - empty: pointers fully equal.
  - count = tail - head, computed modulo 2*DEPTH.
  - Increment wraps idx DEPTH-1 -> 0 and toggles wrap.
- Enqueue:
  - enq_ready = ~full & ~redirect_valid & ~flush.
  - On enq_valid & enq_ready: mem[tail.idx] <= enq_snap at the clock edge, then tail++.
  - enq_valid while ~enq_ready is dropped; the upstream stage holds.
- Redirect:
  - In range means redirect_idx lies between head.idx and tail.idx-1 under wrap semantics; the target's wrap bit is reconstructed from head.
  - If in range: tail <= target+1, keeping the redirected entry and discarding younger ones. rd_snap <= mem[redirect_idx] and rd_valid <= 1 in the next cycle (1-cycle latency). rd_valid is otherwise 0.
  - If out of range (including empty): no pointer change, rd_valid <= 0, redirect_err <= 1 for one cycle.
- Commit:
  - On commit_valid & ~empty: head++.
  - commit_valid while empty is ignored and is a verification assertion failure.
- Simultaneous events:
  - redirect + enq: enq is blocked by enq_ready.
  - redirect + commit: both apply. The range check uses pre-commit head. With redirect_idx == head, the result is head = tail = head+1, i.e. empty, and rd_valid still asserts with the popped snapshot.
  - flush beats everything: head <= tail, rd_valid <= 0, redirect_err <= 0.
- Read data comes from a registered array read. A write to slot i in cycle N is visible to a redirect read in cycle N+1; no same-cycle bypass is needed because enq is blocked during redirect.
- Reset asserted mid-redirect clears rd_valid immediately (async).

Decomposition:
- Shared frontend package:
  - RasCkptSnap packed struct, with fields ordered rasTop, listTop, inflightTop, topInvalid.
  - Pointer typedef {wrap, idx}.
  - Derived SNAP_W constant.
- One sub-module: ckpt_ptr_cmp.
  - Combinational wrap-aware comparator.
  - Outputs full, empty, count, and in_range(idx) given head/tail.
  - Reused for the redirect range check.

Test Plan:
- Reset, then 3 enqs with snaps 0x11, 0x22, 0x33 -> enq_idx 0,1,2; count=3; commit_snap=0x11; pop -> commit_snap=0x22, count=2.
- Fill DEPTH=32 entries -> enq_ready=0 at count=32; 33rd enq dropped; commit once -> enq_ready=1 next cycle, next enq lands at idx 0 with wrap=1.
- Entries 0..9 valid, redirect_idx=4 -> next cycle rd_valid=1, rd_snap=mem[4], count=5, next enq_idx=5.
- head=30, tail=2 (wrapped), redirect_idx=31 -> accepted, tail=0/wrap=1, count=2. redirect_idx=5 -> redirect_err=1, pointers unchanged.
- Same-cycle redirect_idx=head + commit_valid with head=7, tail=12 -> empty=1, head=tail=8, rd_valid=1 with snap of slot 7. Concurrent enq_valid is not accepted.
- flush with count=6 plus redirect -> count=0, rd_valid=0. Async rst pulse during rd_valid -> rd_valid=0 immediately.

Source files
------------

// File: rtl/ras_ckpt_queue_pkg.sv
// Shared frontend types for the RAS checkpoint queue: snapshot layout,
// {wrap, idx} queue pointer and wrap-aware pointer arithmetic.
package ras_ckpt_queue_pkg;

  localparam int DEPTH  = 32;
  localparam int INFL_W = 4;
  localparam int RAS_W  = 4;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int SNAP_W = 2 * (INFL_W + 1) + RAS_W + 1;

  typedef struct packed {
    logic [INFL_W:0]  ras_top;
    logic [INFL_W:0]  list_top;
    logic [RAS_W-1:0] inflight_top;
    logic             top_invalid;
  } ras_ckpt_snap_t;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ckpt_ptr_t;

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  // DEPTH is a power of two, so a plain add over {wrap, idx} wraps idx and toggles wrap.
  function automatic ckpt_ptr_t ptr_add(input ckpt_ptr_t p, input logic [IDX_W:0] n);
    logic [IDX_W:0] sum;
    sum = {p.wrap, p.idx} + n;
    return ckpt_ptr_t'(sum);
  endfunction

endpackage

// File: rtl/ras_ckpt_queue_ptr_cmp.sv
// Combinational wrap-aware head/tail comparator: occupancy flags, count and
// whether a slot index currently holds a live entry.
module ckpt_ptr_cmp
  import ras_ckpt_queue_pkg::*;
(
  input  logic [IDX_W:0]   i_head,
  input  logic [IDX_W:0]   i_tail,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_full,
  output logic             o_empty,
  output logic [IDX_W:0]   o_count,
  output logic [IDX_W-1:0] o_offset,
  output logic             o_in_range
);

  logic [IDX_W:0]   w_count;
  logic [IDX_W-1:0] w_offset;

  assign w_count  = i_tail - i_head;
  assign w_offset = i_idx - i_head[IDX_W-1:0];

  assign o_count    = w_count;
  assign o_offset   = w_offset;
  assign o_empty    = (i_head == i_tail);
  assign o_full     = (i_head[IDX_W-1:0] == i_tail[IDX_W-1:0]) &&
                      (i_head[IDX_W] != i_tail[IDX_W]);
  // Distance from head modulo DEPTH lands inside [head, tail) exactly when below count.
  assign o_in_range = ({1'b0, w_offset} < w_count);

endmodule

// File: rtl/ras_ckpt_queue.sv
// Circular queue of RAS speculative snapshots, one per predicted fetch block:
// replays a snapshot on redirect, retires in order on commit.
module ras_ckpt_queue
  import ras_ckpt_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [SNAP_W-1:0] enq_snap,
  output logic [IDX_W-1:0]  enq_idx,
  input  logic              redirect_valid,
  input  logic [IDX_W-1:0]  redirect_idx,
  output logic              rd_valid,
  output logic [SNAP_W-1:0] rd_snap,
  output logic              redirect_err,
  input  logic              commit_valid,
  output logic [SNAP_W-1:0] commit_snap,
  input  logic              flush,
  output logic [IDX_W:0]    count,
  output logic              empty
);

  ckpt_ptr_t      r_head;
  ckpt_ptr_t      r_tail;
  ckpt_ptr_t      w_head_nxt;
  ckpt_ptr_t      w_tail_nxt;
  ras_ckpt_snap_t r_mem [DEPTH];
  ras_ckpt_snap_t r_rd_snap;
  logic           r_rd_valid;
  logic           r_redirect_err;

  logic             w_full;
  logic             w_empty;
  logic [IDX_W:0]   w_count;
  logic [IDX_W-1:0] w_offset;
  logic             w_in_range;
  logic             w_enq_fire;
  logic             w_commit_fire;
  logic             w_redir_hit;

  ckpt_ptr_cmp u_ptr_cmp (
    .i_head     (r_head),
    .i_tail     (r_tail),
    .i_idx      (redirect_idx),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_offset   (w_offset),
    .o_in_range (w_in_range)
  );

  assign enq_ready     = ~w_full & ~redirect_valid & ~flush;
  assign w_enq_fire    = enq_valid & enq_ready;
  assign w_commit_fire = commit_valid & ~w_empty;
  assign w_redir_hit   = redirect_valid & w_in_range;

  assign enq_idx      = r_tail.idx;
  assign count        = w_count;
  assign empty        = w_empty;
  assign commit_snap  = r_mem[r_head.idx];
  assign rd_valid     = r_rd_valid;
  assign rd_snap      = r_rd_snap;
  assign redirect_err = r_redirect_err;

  // Next head/tail: flush drains, redirect truncates after the target, commit pops.
  always_comb begin
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    if (flush) begin
      w_head_nxt = r_tail;
    end else begin
      if (w_redir_hit) begin
        w_tail_nxt = ptr_add(r_head, {1'b0, w_offset} + PTR_ONE);
      end else if (w_enq_fire) begin
        w_tail_nxt = ptr_add(r_tail, PTR_ONE);
      end else begin
        w_tail_nxt = r_tail;
      end
      if (w_commit_fire) begin
        w_head_nxt = ptr_add(r_head, PTR_ONE);
      end else begin
        w_head_nxt = r_head;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  // Snapshot storage; enq is blocked during redirect so no read bypass is required.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_tail.idx] <= ras_ckpt_snap_t'(enq_snap);
    end
  end

  // Registered redirect replay and range-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid     <= 1'b0;
      r_rd_snap      <= '0;
      r_redirect_err <= 1'b0;
    end else if (flush) begin
      r_rd_valid     <= 1'b0;
      r_redirect_err <= 1'b0;
    end else begin
      r_rd_valid     <= w_redir_hit;
      r_redirect_err <= redirect_valid & ~w_in_range;
      if (w_redir_hit) begin
        r_rd_snap <= r_mem[redirect_idx];
      end
    end
  end

endmodule

// File: tb/tb_ras_ckpt_queue.sv
// Self-checking bench for ras_ckpt_queue: directed scenarios plus random traffic
// against an ordered-list model of live checkpoints.
module tb_ras_ckpt_queue;

  localparam int DEPTH = 32;
  localparam int SW    = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid;
  logic          enq_ready;
  logic [SW-1:0] enq_snap;
  logic [4:0]    enq_idx;
  logic          redirect_valid;
  logic [4:0]    redirect_idx;
  logic          rd_valid;
  logic [SW-1:0] rd_snap;
  logic          redirect_err;
  logic          commit_valid;
  logic [SW-1:0] commit_snap;
  logic          flush;
  logic [5:0]    count;
  logic          empty;

  ras_ckpt_queue dut (
    .clk            (clk),
    .rst            (rst),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_snap       (enq_snap),
    .enq_idx        (enq_idx),
    .redirect_valid (redirect_valid),
    .redirect_idx   (redirect_idx),
    .rd_valid       (rd_valid),
    .rd_snap        (rd_snap),
    .redirect_err   (redirect_err),
    .commit_valid   (commit_valid),
    .commit_snap    (commit_snap),
    .flush          (flush),
    .count          (count),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  // Model: live blocks oldest-first with their slot, plus total blocks ever retired/flushed.
  typedef struct {
    int            slot;
    logic [SW-1:0] snap;
  } ent_t;

  ent_t          q[$];
  int            hd;
  bit            exp_rdv;
  bit            exp_err;
  logic [SW-1:0] exp_rds;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hd      = 0;
    exp_rdv = 1'b0;
    exp_err = 1'b0;
    exp_rds = '0;
  endtask

  function automatic int find_slot(input int idx);
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].slot == idx) return k;
    end
    return -1;
  endfunction

  task automatic drive_idle();
    enq_valid      = 1'b0;
    enq_snap       = '0;
    redirect_valid = 1'b0;
    redirect_idx   = '0;
    commit_valid   = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic step(input bit ev, input logic [SW-1:0] es, input bit rv, input int ri,
                      input bit cv, input bit fl);
    int k;
    bit rdy;
    bit was_empty;
    enq_valid      = ev;
    enq_snap       = es;
    redirect_valid = rv;
    redirect_idx   = ri[4:0];
    commit_valid   = cv;
    flush          = fl;
    #1;
    rdy = (q.size() < DEPTH) && !rv && !fl;
    chk_eq("enq_ready", enq_ready, rdy);
    chk_eq("enq_idx", enq_idx, (hd + q.size()) % DEPTH);
    chk_eq("count_pre", count, q.size());
    chk_eq("empty_pre", empty, q.size() == 0);
    if (q.size() > 0) chk_eq("commit_snap", commit_snap, q[0].snap);

    was_empty = (q.size() == 0);
    exp_rdv   = 1'b0;
    exp_err   = 1'b0;
    if (fl) begin
      hd += q.size();
      q.delete();
    end else begin
      if (rv) begin
        k = find_slot(ri);
        if (k >= 0) begin
          exp_rdv = 1'b1;
          exp_rds = q[k].snap;
          while (q.size() > k + 1) void'(q.pop_back());
        end else begin
          exp_err = 1'b1;
        end
      end else if (ev && rdy) begin
        q.push_back('{slot: (hd + q.size()) % DEPTH, snap: es});
      end
      if (cv && !was_empty) begin
        void'(q.pop_front());
        hd++;
      end
    end

    @(posedge clk);
    #1;
    chk_eq("rd_valid", rd_valid, exp_rdv);
    chk_eq("redirect_err", redirect_err, exp_err);
    chk_eq("count_post", count, q.size());
    chk_eq("empty_post", empty, q.size() == 0);
    if (exp_rdv) chk_eq("rd_snap", rd_snap, exp_rds);
    drive_idle();
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic enq_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, SW'($urandom()), 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    rst = 1'b1;
    #12;
    chk_eq("rst_count", count, 0);
    chk_eq("rst_empty", empty, 1);
    chk_eq("rst_enq_ready", enq_ready, 1);
    chk_eq("rst_rd_valid", rd_valid, 0);
    chk_eq("rst_rd_snap", rd_snap, 0);
    chk_eq("rst_redirect_err", redirect_err, 0);
    rst = 1'b0;

    // Three enqueues then one pop.
    step(1'b1, 15'h11, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 15'h22, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 15'h33, 1'b0, 0, 1'b0, 1'b0);
    chk_eq("basic_commit_snap", commit_snap, 15'h11);
    commit_n(1);
    chk_eq("basic_commit_snap2", commit_snap, 15'h22);

    // Fill to full, dropped enqueue, pop, wrap to slot 0.
    do_reset();
    enq_n(DEPTH);
    chk_eq("full_count", count, DEPTH);
    step(1'b1, 15'h7abc, 1'b0, 0, 1'b0, 1'b0);
    commit_n(1);
    chk_eq("wrap_enq_idx", enq_idx, 0);
    enq_n(1);

    // Redirect into the middle of entries 0..9.
    do_reset();
    enq_n(10);
    step(1'b0, '0, 1'b1, 4, 1'b0, 1'b0);
    chk_eq("redir_enq_idx", enq_idx, 5);
    enq_n(1);

    // Wrapped window head=30, tail=2.
    do_reset();
    enq_n(30);
    commit_n(30);
    enq_n(4);
    step(1'b0, '0, 1'b1, 31, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 3, 1'b0, 1'b0);

    // Redirect at head together with commit and a blocked enqueue.
    do_reset();
    enq_n(12);
    commit_n(7);
    step(1'b1, 15'h1234, 1'b1, 7, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 8, 1'b0, 1'b0);

    // Flush with a concurrent redirect, then async reset while rd_valid is high.
    do_reset();
    enq_n(6);
    step(1'b0, '0, 1'b1, 2, 1'b0, 1'b1);
    enq_n(5);
    step(1'b0, '0, 1'b1, 8, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_eq("async_rst_rd_valid", rd_valid, 0);
    chk_eq("async_rst_count", count, 0);
    #1;
    rst = 1'b0;
    model_reset();

    // Random traffic with shifting bias between filling and draining.
    for (int it = 0; it < 1200; it++) begin
      int  ri;
      bit  ev;
      bit  cv;
      bit  rv;
      bit  fl;
      int  ep;
      ep = ((it / 150) % 2 == 0) ? 75 : 35;
      ev = ($urandom_range(0, 99) < ep);
      cv = ($urandom_range(0, 99) < (100 - ep) / 2 + 10);
      rv = ($urandom_range(0, 99) < 10);
      fl = ($urandom_range(0, 99) < 2);
      if (q.size() > 0 && $urandom_range(0, 9) < 7) ri = q[$urandom_range(0, q.size() - 1)].slot;
      else ri = $urandom_range(0, DEPTH - 1);
      step(ev, SW'($urandom()), rv, ri, cv, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
